// File: rtl/fetch.sv
// Instruction-fetch stage: holds the PC, reads one instruction per cycle of
// the multi-cycle CPU over a req/ack port and presents {pc, inst} to decode.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        IF_valid,
    input  logic        next_fetch,
    input  logic        ID_over,
    input  logic [32:0] jbr_bus,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic        IF_over,
    output logic [63:0] IF_ID_bus,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst,
    output logic [31:0] inst_cnt
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst_r;
    logic [XLEN-1:0]   br_tgt;
    logic [XLEN-1:0]   cnt;
    logic              br_pend;

    // A branch resolved in the retiring cycle overrides any pending one
    logic              jbr_hit_c;
    logic              eff_taken_c;
    logic [XLEN-1:0]   eff_tgt_c;

    assign jbr_hit_c   = ID_over & jbr_bus[32];
    assign eff_taken_c = jbr_hit_c | br_pend;
    assign eff_tgt_c   = jbr_hit_c ? jbr_bus[XLEN-1:0] : br_tgt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            inst_r   <= '0;
            br_pend  <= 1'b0;
            br_tgt   <= '0;
            cnt      <= '0;
            inst_req <= 1'b0;
            IF_over  <= 1'b0;
        end else begin
            IF_over <= 1'b0;
            if (jbr_hit_c) begin
                br_pend <= 1'b1;
                br_tgt  <= jbr_bus[XLEN-1:0];
            end
            case (state)
                IDLE: begin
                    if (IF_valid) begin
                        inst_req <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // Request stays up until acked, regardless of IF_valid
                    if (inst_ack) begin
                        inst_r   <= inst_rdata;
                        inst_req <= 1'b0;
                        IF_over  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    cnt   <= cnt + XLEN'(1);
                    state <= HOLD;
                end
                HOLD: begin
                    if (next_fetch) begin
                        pc      <= eff_taken_c ? eff_tgt_c : pc + XLEN'(4);
                        br_pend <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign inst_addr = {pc[XLEN-1:2], 2'b00};
    assign IF_ID_bus = {pc, inst_r};
    assign IF_pc     = pc;
    assign IF_inst   = inst_r;
    assign inst_cnt  = cnt;

endmodule

// File: tb/tb_fetch.sv
// Randomised scoreboard bench for the fetch stage with a transaction-level PC model.
module tb_fetch;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        IF_valid = 1'b0;
    logic        next_fetch = 1'b0;
    logic        ID_over = 1'b0;
    logic [32:0] jbr_bus = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        IF_over;
    logic [63:0] IF_ID_bus;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;
    logic [31:0] inst_cnt;

    fetch dut (
        .clk        (clk),
        .resetn     (resetn),
        .IF_valid   (IF_valid),
        .next_fetch (next_fetch),
        .ID_over    (ID_over),
        .jbr_bus    (jbr_bus),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_ack   (inst_ack),
        .inst_rdata (inst_rdata),
        .IF_over    (IF_over),
        .IF_ID_bus  (IF_ID_bus),
        .IF_pc      (IF_pc),
        .IF_inst    (IF_inst),
        .inst_cnt   (inst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pushed = 0;
    int   over_seen = 0;

    // reference model state
    logic [31:0] pc_m = 32'h0;
    logic        br_pend_m = 1'b0;
    logic [31:0] br_tgt_m = 32'h0;
    logic [31:0] cnt_m = 32'h0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // monitor: compare every IF_over against the scoreboard, then inst_cnt a cycle later
    exp_t mon_e;
    bit   cnt_pending = 1'b0;
    always @(negedge clk) begin
        if (!resetn) begin
            cnt_pending <= 1'b0;
        end else if (IF_over) begin
            over_seen++;
            if (sbq.size() == 0) begin
                check("unexpected_if_over", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("if_id_bus", IF_ID_bus, {mon_e.pc, mon_e.inst});
                check("if_inst", 64'(IF_inst), 64'(mon_e.inst));
                cnt_pending <= 1'b1;
            end
        end else if (cnt_pending) begin
            check("inst_cnt", 64'(inst_cnt), 64'(mon_e.cnt));
            cnt_pending <= 1'b0;
        end
    end

    // one fetch: request, optional wait cycles, ack; returns at a negedge in HOLD
    task automatic do_fetch(input int waits, input logic [31:0] data, input bit nf_in_req);
        @(negedge clk);
        IF_valid = 1'b1;
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            if (k == 0) IF_valid = 1'($urandom_range(0, 1));
            next_fetch = nf_in_req && (k == 0);
            check("req_high", 64'(inst_req), 64'd1);
            check("req_addr", 64'(inst_addr), 64'({pc_m[31:2], 2'b00}));
            if (k < waits) begin
                inst_ack   = 1'b0;
                inst_rdata = $urandom;
            end else begin
                inst_ack   = 1'b1;
                inst_rdata = data;
                cnt_m      = cnt_m + 32'd1;
                sbq.push_back('{pc_m, data, cnt_m});
                n_pushed++;
            end
        end
        @(negedge clk);
        inst_ack   = 1'b0;
        inst_rdata = $urandom;
        next_fetch = 1'b0;
        IF_valid   = 1'b0;
        check("req_drop", 64'(inst_req), 64'd0);
        @(negedge clk);
        check("if_pc_hold", 64'(IF_pc), 64'(pc_m));
    endtask

    // decode result while holding
    task automatic branch(input bit taken, input logic [31:0] tgt);
        ID_over = 1'b1;
        jbr_bus = {taken, tgt};
        if (taken) begin
            br_pend_m = 1'b1;
            br_tgt_m  = tgt;
        end
        @(negedge clk);
        ID_over = 1'b0;
        jbr_bus = '0;
    endtask

    // retire current instruction, optionally with a same-cycle decode result
    task automatic retire(input bit same, input bit taken, input logic [31:0] tgt);
        next_fetch = 1'b1;
        if (same) begin
            ID_over = 1'b1;
            jbr_bus = {taken, tgt};
        end
        if (same && taken)  pc_m = tgt;
        else if (br_pend_m) pc_m = br_tgt_m;
        else                pc_m = pc_m + 32'd4;
        br_pend_m = 1'b0;
        @(negedge clk);
        next_fetch = 1'b0;
        ID_over    = 1'b0;
        jbr_bus    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req", 64'(inst_req), 64'd0);
        check("rst_over", 64'(IF_over), 64'd0);
        check("rst_bus", IF_ID_bus, 64'h0);
        check("rst_cnt", 64'(inst_cnt), 64'd0);
        check("rst_pc", 64'(IF_pc), 64'd0);
        resetn = 1'b1;

        // zero-wait first fetch, then a delayed ack
        do_fetch(0, 32'h2408_0005, 1'b0);
        retire(1'b0, 1'b0, 32'h0);
        do_fetch(4, $urandom, 1'b0);
        retire(1'b0, 1'b0, 32'h0);
        do_fetch(0, $urandom, 1'b0);
        retire(1'b0, 1'b0, 32'h0);
        do_fetch(1, $urandom, 1'b0);
        retire(1'b0, 1'b0, 32'h0);
        do_fetch(0, $urandom, 1'b0);

        // pending branch, not-taken result leaves it pending
        branch(1'b1, 32'h40);
        branch(1'b0, 32'h99);
        retire(1'b0, 1'b0, 32'h0);
        do_fetch(0, $urandom, 1'b0);
        retire(1'b0, 1'b0, 32'h0);
        do_fetch(0, $urandom, 1'b0);
        retire(1'b1, 1'b1, 32'h80);
        do_fetch(2, $urandom, 1'b0);
        branch(1'b1, 32'h200);
        retire(1'b1, 1'b1, 32'h300);

        // next_fetch outside HOLD is ignored
        next_fetch = 1'b1;
        @(negedge clk);
        next_fetch = 1'b0;
        do_fetch(2, $urandom, 1'b1);

        // misaligned target and PC wrap
        branch(1'b1, 32'h0000_1013);
        retire(1'b0, 1'b0, 32'h0);
        do_fetch(0, $urandom, 1'b0);
        retire(1'b1, 1'b1, 32'hFFFF_FFFC);
        do_fetch(1, $urandom, 1'b0);
        retire(1'b0, 1'b0, 32'h0);

        // fetch counter wrap
        force dut.cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cnt;
        cnt_m = 32'hFFFF_FFFF;
        do_fetch(0, $urandom, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int  nb;
            logic [31:0] t;
            nb = $urandom_range(0, 2);
            for (int j = 0; j < nb; j++) begin
                t = $urandom;
                if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
                branch(1'($urandom_range(0, 1)), t);
            end
            t = $urandom & 32'hFFFF_FFFC;
            retire(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
            do_fetch($urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
        end
        retire(1'b0, 1'b0, 32'h0);

        // reset in the middle of a request
        IF_valid = 1'b1;
        @(negedge clk);
        IF_valid = 1'b0;
        check("req_before_rst", 64'(inst_req), 64'd1);
        resetn     = 1'b0;
        inst_ack   = 1'b1;
        inst_rdata = 32'hDEAD_BEEF;
        #1;
        check("rst_mid_req", 64'(inst_req), 64'd0);
        check("rst_mid_pc", 64'(IF_pc), 64'd0);
        check("rst_mid_cnt", 64'(inst_cnt), 64'd0);
        @(negedge clk);
        resetn   = 1'b1;
        inst_ack = 1'b0;
        pc_m = 32'h0; br_pend_m = 1'b0; br_tgt_m = 32'h0; cnt_m = 32'h0;
        @(negedge clk);
        check("rst_ack_ignored", IF_ID_bus, 64'h0);
        check("rst_no_over", 64'(IF_over), 64'd0);
        do_fetch(3, $urandom, 1'b0);
        @(negedge clk);

        check("over_count", 64'(over_seen), 64'(n_pushed));
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
